// File: rtl/opram_pkg.sv
// Shared constants, sequencer state type and helpers for the parametrised operand RAM.
package opram_pkg;

  localparam int unsigned RD_BYPASS   = 0;
  localparam int unsigned RD_PIPE     = 1;

  localparam int unsigned WR_NORMAL   = 0;
  localparam int unsigned WR_THROUGH  = 1;
  localparam int unsigned WR_RD_FIRST = 2;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  function automatic int unsigned nbe(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

endpackage

// File: rtl/opram_clr_seq.sv
// Clear sequencer: walks every address once, writing zero, while holding off user accesses.
module opram_clr_seq
  import opram_pkg::*;
#(
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ad
);

  clr_state_e        state_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (clr) state_q <= CLEAR;
        end
        CLEAR: begin
          // Counter wraps to zero naturally after the last address.
          cnt_q <= cnt_q + 1'b1;
          if (&cnt_q) state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy   = (state_q == CLEAR);
  assign clr_we = busy;
  assign clr_ad = cnt_q;

endmodule

// File: rtl/opram_param.sv
// Parametrised single-port operand RAM with byte lanes, selectable read/write modes and clear.
module opram_param
  import opram_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 3,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned READ_MODE      = 0,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
  localparam int unsigned NBE           = nbe(DATA_W, BYTE_W),
  localparam int unsigned DEPTH         = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [NBE-1:0]    be,
  input  logic [ADDR_W-1:0] ad,
  input  logic [DATA_W-1:0] din,
  input  logic              clr,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              busy
);

  if ((DATA_W % BYTE_W) != 0 || WRITE_MODE > WR_RD_FIRST) begin : gen_bad_cfg
    $fatal(1, "opram_param: DATA_W must be a multiple of BYTE_W and WRITE_MODE <= 2");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_ad;

  opram_clr_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .busy  (busy),
    .clr_we(clr_we),
    .clr_ad(clr_ad)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              wr_en;

  assign accept  = ce & ~busy;
  assign wr_en   = accept & wre;
  assign rd_word = mem[ad];

  always_comb begin
    merged = rd_word;
    for (int unsigned i = 0; i < NBE; i++) begin
      if (be[i]) merged[i*BYTE_W +: BYTE_W] = din[i*BYTE_W +: BYTE_W];
    end
  end

  // Array is intentionally not reset; the clear sequencer owns initialisation.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_ad] <= '0;
    end else if (wr_en) begin
      mem[ad] <= merged;
    end
  end

  logic [DATA_W-1:0] s1_data_q, s1_data_d;
  logic              s1_valid_q, s1_valid_d;

  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = 1'b0;
    if (accept) begin
      if (!wre) begin
        s1_data_d  = rd_word;
        s1_valid_d = 1'b1;
      end else if (WRITE_MODE == WR_THROUGH) begin
        s1_data_d  = merged;
        s1_valid_d = 1'b1;
      end else if (WRITE_MODE == WR_RD_FIRST) begin
        s1_data_d  = rd_word;
        s1_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
    end
  end

  if (READ_MODE == RD_PIPE) begin : gen_pipe
    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_data_q  <= '0;
        out_valid_q <= 1'b0;
      end else if (oce) begin
        out_data_q  <= s1_data_q;
        out_valid_q <= s1_valid_q;
      end
    end

    assign dout     = out_data_q;
    assign rd_valid = out_valid_q;
  end else begin : gen_bypass
    logic unused_oce;
    assign unused_oce = oce;
    assign dout       = s1_data_q;
    assign rd_valid   = s1_valid_q;
  end

endmodule

// File: tb/tb_opram_param.sv
// Four 16-bit opram_param variants driven in lockstep and checked against a word-level model.
module tb_opram_param;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NDUT  = 4;
  // Write mode per instance; instance 3 is the pipelined-read variant.
  localparam int unsigned WM [NDUT] = '{0, 1, 2, 0};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b0, oce = 1'b0, wre = 1'b0, clr = 1'b0;
  logic [1:0]  be = 2'b00;
  logic [2:0]  ad = 3'd0;
  logic [15:0] din = 16'h0;

  logic [15:0] dout_w  [NDUT];
  logic        valid_w [NDUT];
  logic        busy_w  [NDUT];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] mmem [DEPTH];
  int          clear_left;
  logic [15:0] m_s1_data  [NDUT];
  logic        m_s1_valid [NDUT];
  logic [15:0] m_out_data;
  logic        m_out_valid;

  always #5 clk = ~clk;

  opram_param #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(0),
                .CLEAR_ON_RESET(1)) u0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .clr(clr), .dout(dout_w[0]), .rd_valid(valid_w[0]), .busy(busy_w[0]));

  opram_param #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(1),
                .CLEAR_ON_RESET(1)) u1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .clr(clr), .dout(dout_w[1]), .rd_valid(valid_w[1]), .busy(busy_w[1]));

  opram_param #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .READ_MODE(0), .WRITE_MODE(2),
                .CLEAR_ON_RESET(1)) u2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .clr(clr), .dout(dout_w[2]), .rd_valid(valid_w[2]), .busy(busy_w[2]));

  opram_param #(.DATA_W(16), .ADDR_W(3), .BYTE_W(8), .READ_MODE(1), .WRITE_MODE(0),
                .CLEAR_ON_RESET(1)) u3 (
    .clk(clk), .reset(reset), .ce(ce), .oce(oce), .wre(wre), .be(be), .ad(ad), .din(din),
    .clr(clr), .dout(dout_w[3]), .rd_valid(valid_w[3]), .busy(busy_w[3]));

  function automatic logic [15:0] exp_dout(input int k);
    return (k == 3) ? m_out_data : m_s1_data[k];
  endfunction

  function automatic logic exp_valid(input int k);
    return (k == 3) ? m_out_valid : m_s1_valid[k];
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic        acc;
    logic [15:0] old_w, new_w;
    acc   = ce && (clear_left == 0);
    old_w = mmem[ad];
    new_w = old_w;
    if (be[0]) new_w[7:0]  = din[7:0];
    if (be[1]) new_w[15:8] = din[15:8];
    if (oce) begin
      m_out_data  = m_s1_data[3];
      m_out_valid = m_s1_valid[3];
    end
    for (int k = 0; k < NDUT; k++) begin
      if (!acc) begin
        m_s1_valid[k] = 1'b0;
      end else if (!wre) begin
        m_s1_data[k]  = old_w;
        m_s1_valid[k] = 1'b1;
      end else if (WM[k] == 1) begin
        m_s1_data[k]  = new_w;
        m_s1_valid[k] = 1'b1;
      end else if (WM[k] == 2) begin
        m_s1_data[k]  = old_w;
        m_s1_valid[k] = 1'b1;
      end else begin
        m_s1_valid[k] = 1'b0;
      end
    end
    if (clear_left > 0) begin
      mmem[DEPTH - clear_left] = 16'h0;
      clear_left--;
    end else begin
      if (acc && wre) mmem[ad] = new_w;
      if (clr) clear_left = DEPTH;
    end
  endtask

  task automatic cycle(input logic ce_v, input logic wre_v, input logic [1:0] be_v,
                       input logic [2:0] ad_v, input logic [15:0] din_v, input logic clr_v,
                       input logic oce_v);
    ce = ce_v; wre = wre_v; be = be_v; ad = ad_v; din = din_v; clr = clr_v; oce = oce_v;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      m_s1_data[k]  = 16'h0;
      m_s1_valid[k] = 1'b0;
    end
    m_out_data  = 16'h0;
    m_out_valid = 1'b0;
    clear_left  = DEPTH;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    ce = 1'b0; wre = 1'b0; clr = 1'b0; oce = 1'b0;
    assert_reset();
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (dout_w[k] !== 16'h0 || valid_w[k] !== 1'b0 || busy_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_state u%0d got dout=%h valid=%b busy=%b want 0000/0/1",
                 k, dout_w[k], valid_w[k], busy_w[k]);
      end
    end
    release_reset();
    n = 0;
    while (busy_w[0] === 1'b1 && n < 20) begin
      cycle(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 1'b1);
      n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL reset_busy_len got %0d cycles want %0d", n, DEPTH);
    end
    for (int k = 1; k < NDUT; k++) begin
      checks++;
      if (busy_w[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy_end u%0d got %b want 0", k, busy_w[k]);
      end
    end
  endtask

  task automatic test_clear_contents();
    for (int a = 0; a < DEPTH; a++) begin
      cycle(1'b1, 1'b0, 2'b00, 3'(a), 16'h0, 1'b0, 1'b1);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dout_w[k] !== 16'h0 || valid_w[k] !== 1'b1) begin
          errors++;
          $display("FAIL clear_read u%0d addr %0d got %h/%b want 0000/1",
                   k, a, dout_w[k], valid_w[k]);
        end
      end
    end
  endtask

  task automatic test_byte_lanes();
    cycle(1'b1, 1'b1, 2'b11, 3'd5, 16'hABCD, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b01, 3'd5, 16'h1234, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 3'd5, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dout_w[k] !== 16'hAB34 || valid_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL byte_merge u%0d got %h/%b want ab34/1", k, dout_w[k], valid_w[k]);
      end
    end
    cycle(1'b1, 1'b1, 2'b00, 3'd5, 16'hFFFF, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 3'd5, 16'h0, 1'b0, 1'b1);
    checks++;
    if (dout_w[0] !== 16'hAB34) begin
      errors++;
      $display("FAIL be_zero_write got %h want ab34", dout_w[0]);
    end
  endtask

  task automatic test_write_modes();
    cycle(1'b1, 1'b1, 2'b11, 3'd2, 16'h0011, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 2'b11, 3'd2, 16'h0022, 1'b0, 1'b1);
    checks++;
    if (dout_w[0] !== 16'hAB34 || valid_w[0] !== 1'b0) begin
      errors++;
      $display("FAIL wm_normal_hold got %h/%b want ab34/0", dout_w[0], valid_w[0]);
    end
    checks++;
    if (dout_w[1] !== 16'h0022 || valid_w[1] !== 1'b1) begin
      errors++;
      $display("FAIL wm_through got %h/%b want 0022/1", dout_w[1], valid_w[1]);
    end
    checks++;
    if (dout_w[2] !== 16'h0011 || valid_w[2] !== 1'b1) begin
      errors++;
      $display("FAIL wm_rd_first got %h/%b want 0011/1", dout_w[2], valid_w[2]);
    end
    cycle(1'b1, 1'b0, 2'b00, 3'd2, 16'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dout_w[k] !== 16'h0022 || valid_w[k] !== 1'b1) begin
        errors++;
        $display("FAIL wm_readback u%0d got %h/%b want 0022/1", k, dout_w[k], valid_w[k]);
      end
    end
  endtask

  task automatic test_pipe_oce();
    cycle(1'b1, 1'b1, 2'b11, 3'd3, 16'h005A, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 3'd3, 16'h0, 1'b0, 1'b1);
    checks++;
    if (valid_w[3] !== 1'b0) begin
      errors++;
      $display("FAIL pipe_lat1 got valid=%b want 0", valid_w[3]);
    end
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (dout_w[3] !== 16'h005A || valid_w[3] !== 1'b1) begin
      errors++;
      $display("FAIL pipe_lat2 got %h/%b want 005a/1", dout_w[3], valid_w[3]);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 2'b00, 3'd5, 16'h0, 1'b0, 1'b0);
      checks++;
      if (dout_w[3] !== 16'h005A || valid_w[3] !== 1'b1) begin
        errors++;
        $display("FAIL pipe_oce_hold cyc %0d got %h/%b want 005a/1", i, dout_w[3], valid_w[3]);
      end
    end
    cycle(1'b0, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 1'b1);
    checks++;
    if (dout_w[3] !== 16'hAB34 || valid_w[3] !== 1'b1) begin
      errors++;
      $display("FAIL pipe_oce_resume got %h/%b want ab34/1", dout_w[3], valid_w[3]);
    end
  endtask

  task automatic test_clear_reset();
    int n;
    cycle(1'b1, 1'b1, 2'b11, 3'd6, 16'h6666, 1'b1, 1'b1);
    checks++;
    if (busy_w[0] !== 1'b1) begin
      errors++;
      $display("FAIL clr_start got busy=%b want 1", busy_w[0]);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 2'b11, 3'd0, 16'hDEAD, 1'b0, 1'b1);
      checks++;
      if (busy_w[0] !== 1'b1 || valid_w[0] !== 1'b0 || dout_w[0] !== exp_dout(0)) begin
        errors++;
        $display("FAIL clr_busy_drop cyc %0d got busy=%b %h/%b want 1 %h/0",
                 i, busy_w[0], dout_w[0], valid_w[0], exp_dout(0));
      end
    end
    assert_reset();
    release_reset();
    n = 0;
    while (busy_w[0] === 1'b1 && n < 20) begin
      cycle(1'b1, 1'b1, 2'b11, 3'd0, 16'hBEEF, 1'b0, 1'b1);
      n++;
      checks++;
      if (dout_w[0] !== 16'h0 || valid_w[0] !== 1'b0) begin
        errors++;
        $display("FAIL clr_dout_hold cyc %0d got %h/%b want 0000/0", n, dout_w[0], valid_w[0]);
      end
    end
    checks++;
    if (n != DEPTH) begin
      errors++;
      $display("FAIL clr_restart_len got %0d cycles want %0d", n, DEPTH);
    end
    cycle(1'b1, 1'b0, 2'b00, 3'd0, 16'h0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 2'b00, 3'd6, 16'h0, 1'b0, 1'b1);
    checks++;
    if (dout_w[0] !== 16'h0) begin
      errors++;
      $display("FAIL clr_array_zero addr 6 got %h want 0000", dout_w[0]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 2'($urandom),
            3'($urandom), 16'($urandom), 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 3) != 0));
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if (dout_w[k] !== exp_dout(k) || valid_w[k] !== exp_valid(k) ||
            busy_w[k] !== (clear_left > 0)) begin
          errors++;
          $display("FAIL random cyc %0d u%0d got %h/%b busy=%b want %h/%b busy=%b",
                   i, k, dout_w[k], valid_w[k], busy_w[k], exp_dout(k), exp_valid(k),
                   (clear_left > 0));
        end
      end
    end
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mmem[a] = 16'h0;
    test_reset();
    test_clear_contents();
    test_byte_lanes();
    test_write_modes();
    test_pipe_oce();
    test_clear_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opram_param.md
Name: opram_param

Overview:
Parametrised single-port synchronous RAM. It is the successor to the fixed 8x8 operand RAM, with configurable width and depth, byte-lane write enables, selectable read and write modes, and a hardware clear sequencer. It sits beside the core datapath as operand/scratch storage. The array is inferred; only control and output state are reset.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of BYTE_W
ADDR_W, 3, address width; DEPTH = 2**ADDR_W
BYTE_W, 8, byte-lane width; NBE = DATA_W/BYTE_W
READ_MODE, 0, 0 = bypass (latency 1), 1 = pipelined output register gated by oce (latency 2)
WRITE_MODE, 0, 0 = normal (dout holds on write), 1 = write-through, 2 = read-before-write
CLEAR_ON_RESET, 1, 1 = zero the whole array automatically after reset release

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
ce  in  1  access enable; ignored while busy=1
oce  in  1  output-register enable; used only when READ_MODE=1
wre  in  1  1 = write, 0 = read (qualified by ce)
be  in  NBE  byte-lane write enables; lane i covers din[i*BYTE_W +: BYTE_W]
ad  in  ADDR_W  word address
din  in  DATA_W  write data
clr  in  1  single-cycle pulse that starts an array clear
dout  out  DATA_W  read data
rd_valid  out  1  dout holds data from an accepted access
busy  out  1  clear sequencer active; accesses are dropped

Behaviour:
- Reset values: dout=0, rd_valid=0, stage-1 data/valid=0, busy=CLEAR_ON_RESET, clear address counter=0. Array contents are not reset.
- Sequencer FSM has two states, IDLE and CLEAR.
  - Reset state is CLEAR if CLEAR_ON_RESET=1, otherwise IDLE.
  - IDLE -> CLEAR on clr=1. clr is ignored while in CLEAR.
  - In CLEAR: writes 0 to address cnt each cycle, all lanes, then cnt++. After writing DEPTH-1: cnt wraps to 0 and the state returns to IDLE. busy=0 from the next cycle.
  - A clear takes exactly DEPTH cycles with busy=1.
  - Reset asserted mid-clear restarts at cnt=0 (when CLEAR_ON_RESET=1) or aborts to IDLE (when 0).
- An access is accepted when ce=1 and busy=0. A write with be=0 is accepted but changes nothing.
- Write: lanes with be[i]=1 take din; other lanes keep their old value. The merged word is stored at the next edge.
- Stage-1 register (S1) loads on each accepted access:
  - read: mem[ad]
  - write, WRITE_MODE 0: S1 holds; valid flag cleared
  - write, WRITE_MODE 1: merged new word
  - write, WRITE_MODE 2: old mem[ad]
  - With no accepted access, S1 data holds and the valid flag clears.
- READ_MODE 0: dout=S1 data, rd_valid=S1 valid. Latency is 1 cycle from the accept edge.
- READ_MODE 1:
  - When oce=1, the output register loads S1 data and valid.
  - When oce=0, dout and rd_valid hold.
  - Latency is 2 cycles when oce=1 continuously.
- Read of an address written in the previous cycle returns the new word, for all modes.
- No same-cycle collision exists: the port is single-ported, and sequencer writes block user access.

Decomposition:
- Package opram_pkg holds:
  - read-mode constants RD_BYPASS=0, RD_PIPE=1
  - write-mode constants WR_NORMAL=0, WR_THROUGH=1, WR_RD_FIRST=2
  - state enum {IDLE, CLEAR}
  - function nbe(DATA_W, BYTE_W)
- One sub-module, opram_clr_seq, contains the FSM and address counter. It outputs busy, clr_we and clr_ad.
- The top level holds the array, byte merge, S1 and the output register.
- Elaboration-time check: fatal if DATA_W % BYTE_W != 0 or WRITE_MODE > 2.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=3: release reset. busy stays 1 for exactly 8 cycles. Reading addresses 0..7 then returns 0 with rd_valid=1.
- DATA_W=16, BYTE_W=8: write 0xABCD to addr 5 with be=2'b11, then 0x1234 with be=2'b01. Read addr 5 -> 0xAB34.
- WRITE_MODE=2: mem[2]=0x11; write 0x22 to addr 2 -> dout=0x11 next cycle; read addr 2 -> 0x22. Repeat with WRITE_MODE=1 -> dout=0x22 on the write.
- READ_MODE=1: read addr 3 (=0x5A) with oce=1 -> dout=0x5A two cycles after the accept. Hold oce=0 for 3 cycles -> dout and rd_valid hold.
- Pulse clr while ce/wre are active, then assert reset after 4 clear cycles. After release, busy lasts a full DEPTH cycles. ce during busy leaves the array and dout unchanged.
- WRITE_MODE=0: write 0x77 to addr 1 -> dout unchanged and rd_valid=0 next cycle; the following read of addr 1 -> 0x77.
